ms_timer: RTL and testbench
===========================

Name: ms_timer

Overview:
- Millisecond countdown timer peripheral that consumes the timer control fields of the memory-mapped register file: 16-bit duration, start byte bit 0, interrupt-enable byte bit 0.
- Produces a sticky done flag, which the register file exposes read-only, and a one-cycle interrupt request that goes to the interrupt status logic.
- Sits directly downstream of the register file, on the same clk/rst domain.

Parameters:
- TICKS_PER_MS, 27000: clk cycles per millisecond (27 MHz board clock). Must be >= 1. Prescaler width is clog2(TICKS_PER_MS), minimum 1 bit.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- time_ms  input  16  requested duration in ms; sampled only on a start edge
- start  input  1  level from the start register (bit 0); rising edge arms the timer
- irq_enable  input  1  level from the interrupt-enable register (bit 0)
- done  output  1  sticky expiry flag
- irq  output  1  single-cycle interrupt request
- busy  output  1  high while counting
- remaining_ms  output  16  milliseconds still to elapse (readback/debug)

Behaviour:
- Reset (synchronous, rst high at a posedge):
  - state IDLE.
  - done=0, irq=0, busy=0, remaining_ms=0.
  - Prescaler=0, start_d=0.
  - A start held high on the first cycle after reset counts as a rising edge.
- Edge detect: start_d registers start every cycle. start_edge = start & ~start_d. A level held high never retriggers. A falling edge is ignored.
- States:
  - IDLE: done=0, busy=0.
  - RUNNING: busy=1, done=0.
  - DONE: done=1, busy=0.
  - Outputs are registered; the state register drives busy/done.
- start_edge in any state (clock edge E):
  - remaining_ms <= time_ms, prescaler <= 0, done <= 0.
  - If time_ms != 0: state <= RUNNING.
  - If time_ms == 0: state <= DONE immediately. done=1 and irq=irq_enable are visible after edge E, i.e. 1-cycle latency.
- RUNNING:
  - The prescaler increments each cycle.
  - At prescaler == TICKS_PER_MS-1: prescaler <= 0 and remaining_ms decrements.
  - When remaining_ms == 1 at that terminal tick: remaining_ms <= 0, state <= DONE, done <= 1, irq <= irq_enable (sampled that cycle).
- Latency: done rises exactly time_ms*TICKS_PER_MS cycles after edge E, for time_ms >= 1.
- irq:
  - Asserted for exactly one cycle, coincident with the cycle done first reads 1.
  - Never asserted if irq_enable is low at expiry.
  - Enabling irq_enable later while in DONE does not produce a late irq.
- DONE: holds until the next start_edge or rst. remaining_ms stays 0.
- Retrigger: a start_edge while RUNNING restarts with the new time_ms and clears the prescaler. The old count is discarded.
- Simultaneous start_edge and terminal expiry: start wins. No done, no irq, count reloads.
- time_ms changes while RUNNING are ignored (value latched on the edge).
- TICKS_PER_MS=1: remaining_ms decrements every cycle. Same rules apply.
- Max duration time_ms=65535: no overflow. The decrement never goes below 0.
- Reset mid-run: aborts immediately to reset values. No irq emitted.

Test Plan:
- TICKS_PER_MS=4, time_ms=3, pulse start 0->1 at edge E: busy=1 from E+1. remaining_ms steps 3,2,1 every 4 cycles. done and busy=0 exactly at E+12. irq high only at cycle E+12 with irq_enable=1.
- time_ms=0, start edge with irq_enable=1: done=1 and irq=1 one cycle later. irq low the next cycle. done stays 1.
- time_ms=2, irq_enable=0: done at E+8, irq never asserts. Setting irq_enable=1 afterwards produces no irq. Holding start high 20 more cycles causes no retrigger. Drop start then raise it again: done clears and the count restarts.
- Retrigger: time_ms=5, start edge. At 6 cycles in, drop start, set time_ms=2, raise start (new edge E2): done at E2+8, not at the original deadline. Also place the edge exactly on an expiry cycle: no done, no irq.
- Reset mid-run: time_ms=10, assert rst at cycle 15 for 1 cycle. All outputs 0 next cycle. No irq.
- Parameter sweep TICKS_PER_MS=1, time_ms=65535: done at exactly 65535 cycles after the edge. remaining_ms is monotonic and never underflows.

Source files
------------

// File: rtl/ms_timer.sv
// Millisecond countdown timer: arms on a rising edge of start and counts
// time_ms milliseconds of TICKS_PER_MS clocks. It then raises a sticky done flag and a one-cycle irq.
module ms_timer #(
  parameter int unsigned TICKS_PER_MS = 27000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] time_ms,
  input  logic        start,
  input  logic        irq_enable,
  output logic        done,
  output logic        irq,
  output logic        busy,
  output logic [15:0] remaining_ms
);

  localparam int unsigned PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_MS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUNNING = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_n;
  logic [15:0]   remaining_n;
  logic          start_d;
  logic          start_edge;
  logic          ms_tick;
  logic          irq_n;
  logic          done_n;
  logic          busy_n;

  assign start_edge = start & ~start_d;
  assign ms_tick    = (presc == PRESC_TERM);

  // Next-state logic; a start edge outranks expiry in every state.
  always_comb begin
    state_n     = state;
    presc_n     = presc;
    remaining_n = remaining_ms;
    irq_n       = 1'b0;

    if (start_edge) begin
      remaining_n = time_ms;
      presc_n     = '0;
      if (time_ms == 16'd0) begin
        state_n = S_DONE;
        irq_n   = irq_enable;
      end else begin
        state_n = S_RUNNING;
      end
    end else begin
      case (state)
        S_RUNNING: begin
          if (ms_tick) begin
            presc_n = '0;
            if (remaining_ms <= 16'd1) begin
              remaining_n = 16'd0;
              state_n     = S_DONE;
              irq_n       = irq_enable;
            end else begin
              remaining_n = remaining_ms - 16'd1;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        S_DONE: begin
          state_n = S_DONE;
        end
        S_IDLE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n     = S_IDLE;
          remaining_n = 16'd0;
          presc_n     = '0;
        end
      endcase
    end

    done_n = (state_n == S_DONE);
    busy_n = (state_n == S_RUNNING);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      presc        <= '0;
      remaining_ms <= 16'd0;
      start_d      <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      irq          <= 1'b0;
    end else begin
      state        <= state_n;
      presc        <= presc_n;
      remaining_ms <= remaining_n;
      start_d      <= start;
      done         <= done_n;
      busy         <= busy_n;
      irq          <= irq_n;
    end
  end

endmodule

// File: tb/tb_ms_timer.sv
// Bench for ms_timer: a TICKS_PER_MS=4 instance is checked against a deadline-based model.
// A TICKS_PER_MS=1 instance covers the full 65535 ms sweep.
module tb_ms_timer;

  localparam int unsigned TA = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] time_a, time_b;
  logic        start_a, start_b, irqen_a, irqen_b;
  logic        done_a, irq_a, busy_a, done_b, irq_b, busy_b;
  logic [15:0] rem_a, rem_b;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  ms_timer #(.TICKS_PER_MS(TA)) u_a (
    .clk(clk), .rst(rst), .time_ms(time_a), .start(start_a), .irq_enable(irqen_a),
    .done(done_a), .irq(irq_a), .busy(busy_a), .remaining_ms(rem_a)
  );

  ms_timer #(.TICKS_PER_MS(1)) u_b (
    .clk(clk), .rst(rst), .time_ms(time_b), .start(start_b), .irq_enable(irqen_b),
    .done(done_b), .irq(irq_b), .busy(busy_b), .remaining_ms(rem_b)
  );

  // Reference model for u_a: each arm records an absolute deadline in clock edges.
  longint cyc = 0;
  longint m_deadline = 0;
  bit     m_run = 1'b0, m_done = 1'b0, m_irq = 1'b0, m_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_run = 1'b0; m_done = 1'b0; m_irq = 1'b0; m_prev = 1'b0;
    end else begin
      m_irq = 1'b0;
      if (start_a && !m_prev) begin
        if (time_a == 16'd0) begin
          m_run = 1'b0; m_done = 1'b1; m_irq = irqen_a;
        end else begin
          m_run = 1'b1; m_done = 1'b0;
          m_deadline = cyc + longint'(time_a) * TA;
        end
      end else if (m_run && cyc == m_deadline) begin
        m_run = 1'b0; m_done = 1'b1; m_irq = irqen_a;
      end
      m_prev = start_a;
    end
  end

  function automatic logic [15:0] exp_rem();
    if (!m_run) return 16'd0;
    return 16'((m_deadline - cyc + TA - 1) / TA);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; time_a = 16'd0; time_b = 16'd0;
    irqen_a = 1'b0; irqen_b = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({done_a, busy_a, irq_a, rem_a, done_b, busy_b, irq_b, rem_b} !== 38'd0)
      $display("FAIL reset_state: a=%b/%b/%b/%0d b=%b/%b/%b/%0d want all 0",
               done_a, busy_a, irq_a, rem_a, done_b, busy_b, irq_b, rem_b);
    else n_pass++;
    // start already high when reset releases must arm the timer
    start_a = 1'b1; time_a = 16'd1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy_a, done_a, rem_a} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL start_after_reset: busy/done/rem got %b/%b/%0d want 1/0/1", busy_a, done_a, rem_a);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_total++;
      if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
        $display("FAIL post_reset_run cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                 done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    int rise_at = -1;
    int irq_cnt = 0;
    @(negedge clk);
    start_a = 1'b0; irqen_a = 1'b1; time_a = 16'd3;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_total++;
      if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
        $display("FAIL basic cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                 done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
      else n_pass++;
      if (done_a && rise_at < 0) rise_at = i;
      if (irq_a) irq_cnt++;
    end
    n_total++;
    if (rise_at !== 12 || irq_cnt !== 1)
      $display("FAIL basic_latency: done at E+%0d irq pulses %0d want E+12 and 1", rise_at, irq_cnt);
    else n_pass++;
  endtask

  task automatic test_zero();
    @(negedge clk);
    start_a = 1'b0; time_a = 16'd0; irqen_a = 1'b1;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    n_total++;
    if ({done_a, irq_a, busy_a, rem_a} !== {1'b1, 1'b1, 1'b0, 16'd0})
      $display("FAIL zero_first: done/irq/busy/rem got %b/%b/%b/%0d want 1/1/0/0", done_a, irq_a, busy_a, rem_a);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done_a, irq_a} !== 2'b10)
      $display("FAIL zero_second: done/irq got %b/%b want 1/0", done_a, irq_a);
    else n_pass++;
  endtask

  task automatic test_no_irq();
    int rise_at = -1;
    int irq_cnt = 0;
    @(negedge clk);
    start_a = 1'b0; time_a = 16'd2; irqen_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_total++;
      if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
        $display("FAIL no_irq cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                 done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
      else n_pass++;
      if (done_a && rise_at < 0) rise_at = i;
      if (irq_a) irq_cnt++;
    end
    irqen_a = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (irq_a) irq_cnt++;
      n_total++;
      if ({done_a, busy_a} !== 2'b10)
        $display("FAIL held_start cyc %0d: done/busy got %b/%b want 1/0", cyc, done_a, busy_a);
      else n_pass++;
    end
    n_total++;
    if (rise_at !== 8 || irq_cnt !== 0)
      $display("FAIL no_irq_summary: done at E+%0d irq pulses %0d want E+8 and 0", rise_at, irq_cnt);
    else n_pass++;
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    n_total++;
    if ({done_a, busy_a, rem_a} !== {1'b0, 1'b1, 16'd2})
      $display("FAIL rearm: done/busy/rem got %b/%b/%0d want 0/1/2", done_a, busy_a, rem_a);
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int rise_at = -1;
    int irq_cnt = 0;
    @(negedge clk);
    start_a = 1'b0; irqen_a = 1'b1; time_a = 16'd5;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    time_a = 16'd2; start_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_total++;
      if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
        $display("FAIL retrigger cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                 done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
      else n_pass++;
      if (done_a && rise_at < 0) rise_at = i;
      if (irq_a) irq_cnt++;
    end
    n_total++;
    if (rise_at !== 8 || irq_cnt !== 1)
      $display("FAIL retrigger_latency: done at E2+%0d irq pulses %0d want E2+8 and 1", rise_at, irq_cnt);
    else n_pass++;
    // New edge landing exactly on the expiry edge of a 2 ms run.
    start_a = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) start_a = 1'b0;
      if (i == 7) begin
        start_a = 1'b1; time_a = 16'd3;
      end
    end
    @(negedge clk);
    n_total++;
    if ({done_a, irq_a, busy_a, rem_a} !== {1'b0, 1'b0, 1'b1, 16'd3})
      $display("FAIL start_wins: done/irq/busy/rem got %b/%b/%b/%0d want 0/0/1/3", done_a, irq_a, busy_a, rem_a);
    else n_pass++;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      n_total++;
      if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
        $display("FAIL after_collision cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                 done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int irq_cnt = 0;
    @(negedge clk);
    start_a = 1'b0; irqen_a = 1'b1; time_a = 16'd10;
    @(negedge clk);
    start_a = 1'b1;
    for (int i = 0; i < 14; i++) @(negedge clk);
    rst = 1'b1; start_a = 1'b0;
    @(negedge clk);
    n_total++;
    if ({done_a, busy_a, irq_a, rem_a} !== 19'd0)
      $display("FAIL reset_mid: got %b/%b/%b/%0d want 0/0/0/0", done_a, busy_a, irq_a, rem_a);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (irq_a || done_a || busy_a) irq_cnt++;
    end
    n_total++;
    if (irq_cnt !== 0)
      $display("FAIL reset_mid_quiet: %0d cycles with irq/done/busy set, want 0", irq_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      start_a = 1'($urandom_range(0, 1));
      time_a  = 16'($urandom_range(0, 5));
      irqen_a = 1'($urandom_range(0, 1));
      rst     = ($urandom_range(0, 30) == 0);
      for (int k = $urandom_range(1, 25); k > 0; k--) begin
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({done_a, busy_a, irq_a, rem_a} !== {m_done, m_run, m_irq, exp_rem()})
          $display("FAIL random cyc %0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", cyc,
                   done_a, busy_a, irq_a, rem_a, m_done, m_run, m_irq, exp_rem());
        else n_pass++;
      end
    end
  endtask

  task automatic test_sweep();
    @(negedge clk);
    rst = 1'b0; start_b = 1'b0; time_b = 16'hFFFF; irqen_b = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    for (int i = 0; i <= 65535; i++) begin
      @(negedge clk);
      if (i == 100) time_b = 16'd5;
      n_total++;
      if ({done_b, busy_b, irq_b, rem_b} !== {1'(i == 65535), 1'(i < 65535), 1'(i == 65535), 16'(65535 - i)})
        $display("FAIL sweep E+%0d: done/busy/irq/rem got %b/%b/%b/%0d want %b/%b/%b/%0d", i,
                 done_b, busy_b, irq_b, rem_b, i == 65535, i < 65535, i == 65535, 65535 - i);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if ({done_b, irq_b, rem_b} !== {1'b1, 1'b0, 16'd0})
      $display("FAIL sweep_hold: done/irq/rem got %b/%b/%0d want 1/0/0", done_b, irq_b, rem_b);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; time_a = 16'd0; time_b = 16'd0;
    irqen_a = 1'b0; irqen_b = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_no_irq();
    test_retrigger();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
